// File: rtl/tmds_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tmds_pkg
//  Purpose  : Shared TMDS symbol width, control tokens, FSM states and the
//             decoded-symbol record used by the channel decoder.
//  Revision : 1.0  initial release
// ============================================================================
package tmds_pkg;

  localparam int TMDS_W = 10;

  localparam logic [TMDS_W-1:0] CTRL_TOKEN_00 = 10'h354;
  localparam logic [TMDS_W-1:0] CTRL_TOKEN_01 = 10'h0AB;
  localparam logic [TMDS_W-1:0] CTRL_TOKEN_10 = 10'h154;
  localparam logic [TMDS_W-1:0] CTRL_TOKEN_11 = 10'h2AB;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  typedef struct packed {
    logic       is_ctrl;
    logic [1:0] ctrl;
    logic [7:0] data;
  } sym_dec_t;

endpackage
`default_nettype wire

// File: rtl/tmds_symbol_decode.sv
`default_nettype none
// ============================================================================
//  Module   : tmds_symbol_decode
//  Purpose  : Combinational 10b TMDS symbol to {is_ctrl, ctrl, data} mapping.
//  Revision : 1.0  initial release
// ============================================================================
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [TMDS_W-1:0] i_symbol,
  output sym_dec_t          o_dec
);

  logic [7:0] w_inv;
  logic [7:0] w_q;

  always_comb begin
    w_inv = i_symbol[9] ? ~i_symbol[7:0] : i_symbol[7:0];
    w_q    = '0;
    w_q[0] = w_inv[0];
    // bit 8 selects XOR vs XNOR transition coding
    for (int i = 1; i < 8; i++) begin
      w_q[i] = i_symbol[8] ? (w_inv[i] ^ w_inv[i-1]) : ~(w_inv[i] ^ w_inv[i-1]);
    end

    o_dec.is_ctrl = 1'b0;
    o_dec.ctrl    = 2'b00;
    o_dec.data    = w_q;
    case (i_symbol)
      CTRL_TOKEN_00: begin o_dec.is_ctrl = 1'b1; o_dec.ctrl = 2'b00; o_dec.data = 8'h00; end
      CTRL_TOKEN_01: begin o_dec.is_ctrl = 1'b1; o_dec.ctrl = 2'b01; o_dec.data = 8'h00; end
      CTRL_TOKEN_10: begin o_dec.is_ctrl = 1'b1; o_dec.ctrl = 2'b10; o_dec.data = 8'h00; end
      CTRL_TOKEN_11: begin o_dec.is_ctrl = 1'b1; o_dec.ctrl = 2'b11; o_dec.data = 8'h00; end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/tmds_channel_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tmds_channel_decoder
//  Purpose  : Word-aligns one deserialized TMDS channel by hunting control-token
//             runs, then decodes symbols to pixel data, DE and {C1,C0}.
//  Revision : 1.0  initial release
// ============================================================================
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int LOCK_COUNT   = 8,
  parameter int SEARCH_DWELL = 2048,
  parameter int LOSS_TIMEOUT = 4096
) (
  input  logic              clk_pixel,
  input  logic              reset,
  input  logic [TMDS_W-1:0] in_symbol,
  output logic [7:0]        out_data,
  output logic              out_de,
  output logic [1:0]        out_ctrl,
  output logic              locked,
  output logic [3:0]        out_offset
);

  localparam int c_run_w   = $clog2(LOCK_COUNT) + 1;
  localparam int c_dwell_w = $clog2(SEARCH_DWELL) + 1;
  localparam int c_loss_w  = $clog2(LOSS_TIMEOUT) + 1;

  localparam logic [c_run_w-1:0]   c_run_last   = c_run_w'(LOCK_COUNT - 1);
  localparam logic [c_dwell_w-1:0] c_dwell_last = c_dwell_w'(SEARCH_DWELL - 1);
  localparam logic [c_loss_w-1:0]  c_loss_last  = c_loss_w'(LOSS_TIMEOUT - 1);

  state_t                r_state;
  logic [3:0]            r_offset;
  logic [c_run_w-1:0]    r_run_cnt;
  logic [c_dwell_w-1:0]  r_dwell_cnt;
  logic [c_loss_w-1:0]   r_loss_cnt;
  logic                  r_locked;
  logic [TMDS_W-1:0]     r_prev;
  sym_dec_t              r_s1_dec;

  logic [2*TMDS_W-1:0]   w_window;
  logic [TMDS_W-1:0]     w_aligned;
  logic [3:0]            w_next_offset;
  sym_dec_t              w_dec;

  // the previous word occupies the low half, so offset 0 selects it unchanged
  assign w_window      = {in_symbol, r_prev};
  assign w_aligned     = w_window[r_offset +: TMDS_W];
  assign w_next_offset = (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;

  assign locked     = r_locked;
  assign out_offset = r_offset;

  tmds_symbol_decode u_decode (
    .i_symbol (w_aligned),
    .o_dec    (w_dec)
  );

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      r_state     <= SEARCH;
      r_offset    <= 4'd0;
      r_run_cnt   <= '0;
      r_dwell_cnt <= '0;
      r_loss_cnt  <= '0;
      r_locked    <= 1'b0;
    end else begin
      case (r_state)
        SEARCH: begin
          // lock takes priority over a dwell expiry in the same cycle
          if (w_dec.is_ctrl && (r_run_cnt == c_run_last)) begin
            r_state     <= LOCKED;
            r_locked    <= 1'b1;
            r_run_cnt   <= '0;
            r_dwell_cnt <= '0;
            r_loss_cnt  <= '0;
          end else if (r_dwell_cnt == c_dwell_last) begin
            r_offset    <= w_next_offset;
            r_run_cnt   <= '0;
            r_dwell_cnt <= '0;
          end else begin
            r_dwell_cnt <= r_dwell_cnt + 1'b1;
            r_run_cnt   <= w_dec.is_ctrl ? r_run_cnt + 1'b1 : '0;
          end
        end
        LOCKED: begin
          if (w_dec.is_ctrl) begin
            r_loss_cnt <= '0;
          end else if (r_loss_cnt == c_loss_last) begin
            r_state     <= SEARCH;
            r_locked    <= 1'b0;
            r_offset    <= w_next_offset;
            r_run_cnt   <= '0;
            r_dwell_cnt <= '0;
            r_loss_cnt  <= '0;
          end else begin
            r_loss_cnt <= r_loss_cnt + 1'b1;
          end
        end
        default: r_state <= SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      r_prev   <= '0;
      r_s1_dec <= '0;
      out_data <= 8'h00;
      out_de   <= 1'b0;
      out_ctrl <= 2'b00;
    end else begin
      r_prev   <= in_symbol;
      r_s1_dec <= w_dec;
      if (!r_locked) begin
        out_data <= 8'h00;
        out_de   <= 1'b0;
        out_ctrl <= 2'b00;
      end else if (r_s1_dec.is_ctrl) begin
        out_data <= 8'h00;
        out_de   <= 1'b0;
        out_ctrl <= r_s1_dec.ctrl;
      end else begin
        out_data <= r_s1_dec.data;
        out_de   <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
